// File: rtl/fl_frame_arbiter_if.sv
// FrameLink bundle for the frame arbiter: IF_COUNT packed RX streams and one merged TX stream.
// slave = arbiter side, master = traffic source/sink side.
interface fl_frame_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IF_COUNT   = 4
);
    localparam int unsigned DREM_WIDTH  = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
    localparam int unsigned IFNUM_WIDTH = $clog2(IF_COUNT);

    logic [IF_COUNT*DATA_WIDTH-1:0] rx_data;
    logic [IF_COUNT*DREM_WIDTH-1:0] rx_rem;
    logic [IF_COUNT-1:0]            rx_sof_n;
    logic [IF_COUNT-1:0]            rx_sop_n;
    logic [IF_COUNT-1:0]            rx_eop_n;
    logic [IF_COUNT-1:0]            rx_eof_n;
    logic [IF_COUNT-1:0]            rx_src_rdy_n;
    logic [IF_COUNT-1:0]            rx_dst_rdy_n;

    logic [DATA_WIDTH-1:0]          tx_data;
    logic [DREM_WIDTH-1:0]          tx_rem;
    logic                           tx_sof_n;
    logic                           tx_sop_n;
    logic                           tx_eop_n;
    logic                           tx_eof_n;
    logic                           tx_src_rdy_n;
    logic                           tx_dst_rdy_n;
    logic [IFNUM_WIDTH-1:0]         tx_ifnum;

    modport slave (
        input  rx_data, rx_rem, rx_sof_n, rx_sop_n, rx_eop_n, rx_eof_n, rx_src_rdy_n,
        output rx_dst_rdy_n,
        output tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n, tx_src_rdy_n, tx_ifnum,
        input  tx_dst_rdy_n
    );

    modport master (
        output rx_data, rx_rem, rx_sof_n, rx_sop_n, rx_eop_n, rx_eof_n, rx_src_rdy_n,
        input  rx_dst_rdy_n,
        input  tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n, tx_src_rdy_n, tx_ifnum,
        output tx_dst_rdy_n
    );
endinterface

// File: rtl/fl_frame_arbiter.sv
// Round-robin FrameLink arbiter: locks onto one RX input for a whole frame (SOF..EOF) and
// passes it straight through to TX with no buffering; one idle cycle separates frames.
module fl_frame_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IF_COUNT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    fl_frame_arbiter_if.slave fl
);
    localparam int unsigned DREM_WIDTH  = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
    localparam int unsigned IFNUM_WIDTH = $clog2(IF_COUNT);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IFNUM_WIDTH-1:0] ptr_q, ptr_d;
    logic [IFNUM_WIDTH-1:0] grant_q, grant_d;

    logic [IF_COUNT-1:0]    req_c;
    logic                   req_found_c;
    logic [IFNUM_WIDTH-1:0] req_idx_c;
    logic [IFNUM_WIDTH-1:0] cand_c;
    logic                   locked_c;
    logic                   xfer_c;

    assign req_c    = ~fl.rx_src_rdy_n & ~fl.rx_sof_n;
    // Reset masks the pass-through immediately, not just from the next cycle.
    assign locked_c = (state_q == LOCKED) && !reset;
    assign xfer_c   = locked_c && !fl.rx_src_rdy_n[grant_q] && !fl.tx_dst_rdy_n;

    // First requester at or after ptr; the index wraps because IF_COUNT is a power of two.
    always_comb begin
        req_found_c = 1'b0;
        req_idx_c   = ptr_q;
        cand_c      = ptr_q;
        for (int unsigned i = 0; i < IF_COUNT; i++) begin
            cand_c = ptr_q + IFNUM_WIDTH'(i);
            if (!req_found_c && req_c[cand_c]) begin
                req_found_c = 1'b1;
                req_idx_c   = cand_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (req_found_c) begin
                    grant_d = req_idx_c;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Only EOF releases the lock; malformed delimiters are passed through as-is.
                if (xfer_c && !fl.rx_eof_n[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = grant_q + IFNUM_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational pass-through of the granted input; everyone else sees backpressure.
    always_comb begin
        fl.tx_data      = fl.rx_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        fl.tx_rem       = fl.rx_rem[grant_q*DREM_WIDTH +: DREM_WIDTH];
        fl.tx_sof_n     = fl.rx_sof_n[grant_q];
        fl.tx_sop_n     = fl.rx_sop_n[grant_q];
        fl.tx_eop_n     = fl.rx_eop_n[grant_q];
        fl.tx_eof_n     = fl.rx_eof_n[grant_q];
        fl.tx_src_rdy_n = 1'b1;
        fl.tx_ifnum     = grant_q;
        fl.rx_dst_rdy_n = '1;
        if (locked_c) begin
            fl.tx_src_rdy_n          = fl.rx_src_rdy_n[grant_q];
            fl.rx_dst_rdy_n[grant_q] = fl.tx_dst_rdy_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end
endmodule

// File: tb/tb_fl_frame_arbiter.sv
// Scoreboard bench for fl_frame_arbiter: per-input expected word queues, round-robin order
// expectations and timing expectations are queued by stimulus and consumed by a TX monitor.
module tb_fl_frame_arbiter;
    localparam int unsigned DW  = 16;
    localparam int unsigned NIF = 4;
    localparam int unsigned RW  = 1;
    localparam int unsigned IW  = 2;
    localparam int unsigned BPW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] rem;
        logic          sof_n;
        logic          sop_n;
        logic          eop_n;
        logic          eof_n;
    } word_t;

    typedef struct {
        word_t       w;
        int unsigned gap;
    } drv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_dst_n = 1'b0;
    word_t cur_w [NIF];
    logic  cur_src_n [NIF];

    drv_t        drv_q [NIF][$];
    word_t       exp_q [NIF][$];
    int unsigned order_q[$];
    longint      lat_q[$];

    longint      cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          check_gap = 1'b0;
    bit          check_lat = 1'b0;
    int unsigned stall_pct = 0;
    int unsigned xfer_cnt [NIF];

    fl_frame_arbiter_if #(.DATA_WIDTH(DW), .IF_COUNT(NIF)) fl ();

    fl_frame_arbiter #(.DATA_WIDTH(DW), .IF_COUNT(NIF)) dut (
        .clk   (clk),
        .reset (rst),
        .fl    (fl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fl.tx_dst_rdy_n = tx_dst_n;

    always_comb begin
        for (int i = 0; i < NIF; i++) begin
            fl.rx_data[i*DW +: DW]  = cur_w[i].data;
            fl.rx_rem[i*RW +: RW]   = cur_w[i].rem;
            fl.rx_sof_n[i]          = cur_w[i].sof_n;
            fl.rx_sop_n[i]          = cur_w[i].sop_n;
            fl.rx_eop_n[i]          = cur_w[i].eop_n;
            fl.rx_eof_n[i]          = cur_w[i].eof_n;
            fl.rx_src_rdy_n[i]      = cur_src_n[i];
        end
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NIF; i++)
            if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int unsigned pick_gap(input int unsigned gap_max);
        if (gap_max == 0 || $urandom_range(3, 0) != 0) return 0;
        return $urandom_range(gap_max, 1);
    endfunction

    task automatic push_word(input int unsigned i, input word_t x, input int unsigned gap);
        drv_t d;
        d.w   = x;
        d.gap = gap;
        drv_q[i].push_back(d);
        exp_q[i].push_back(x);
    endtask

    // Three-part frame; part sizes in bytes, data tagged with the input index.
    task automatic gen_frame(input int unsigned i, input int unsigned b0, input int unsigned b1,
                             input int unsigned b2, input int unsigned gap_max);
        int unsigned bytes [3];
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        for (int p = 0; p < 3; p++) begin
            int unsigned nw;
            nw = (bytes[p] + BPW - 1) / BPW;
            for (int unsigned w = 0; w < nw; w++) begin
                word_t x;
                x.data              = DW'($urandom);
                x.data[DW-1 -: IW]  = IW'(i);
                x.rem   = (w == nw - 1) ? RW'((bytes[p] - 1) % BPW) : RW'(BPW - 1);
                x.sof_n = !(p == 0 && w == 0);
                x.sop_n = !(w == 0);
                x.eop_n = !(w == nw - 1);
                x.eof_n = !(p == 2 && w == nw - 1);
                push_word(i, x, pick_gap(gap_max));
            end
        end
    endtask

    task automatic gen_single(input int unsigned i);
        word_t x;
        x.data             = DW'($urandom);
        x.data[DW-1 -: IW] = IW'(i);
        x.rem   = RW'($urandom);
        x.sof_n = 1'b0;
        x.sop_n = 1'b0;
        x.eop_n = 1'b0;
        x.eof_n = 1'b0;
        push_word(i, x, 0);
    endtask

    task automatic flush_all();
        for (int i = 0; i < NIF; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
            cur_src_n[i] = 1'b1;
        end
    endtask

    // One clock: note handshakes before the edge, then present the next words after it.
    task automatic step();
        logic [NIF-1:0] x;
        @(negedge clk);
        x = ~fl.rx_src_rdy_n & ~fl.rx_dst_rdy_n;
        @(posedge clk);
        #1;
        for (int i = 0; i < NIF; i++) begin
            if (x[i] && drv_q[i].size() > 0) begin
                void'(drv_q[i].pop_front());
                xfer_cnt[i]++;
            end
            if (drv_q[i].size() == 0) begin
                cur_src_n[i] = 1'b1;
            end else if (drv_q[i][0].gap > 0) begin
                drv_q[i][0].gap = drv_q[i][0].gap - 1;
                cur_src_n[i]    = 1'b1;
            end else begin
                if (check_lat && cur_src_n[i] && !drv_q[i][0].w.sof_n) lat_q.push_back(cyc + 1);
                cur_w[i]     = drv_q[i][0].w;
                cur_src_n[i] = 1'b0;
            end
        end
        tx_dst_n = (stall_pct > 0) && ($urandom_range(99, 0) < stall_pct);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (!all_empty() && n < budget) begin
            step();
            n++;
        end
        check("drain_before_timeout", 64'(all_empty()), 64'd1);
        repeat (3) step();
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst = 1'b1;
        flush_all();
        repeat (cycles) step();
        rst = 1'b0;
        step();
    endtask

    // TX monitor: every transfer is matched against the head of the granted input's queue.
    logic        in_frame = 1'b0;
    int unsigned cur_if = 0;
    longint      last_eof = -1;
    logic        rst_prev = 1'b0;

    always @(negedge clk) begin
        int unsigned g;
        word_t       act;
        g = 32'(fl.tx_ifnum);
        if (rst || rst_prev) begin
            check("reset_tx_src_rdy_n", 64'(fl.tx_src_rdy_n), 64'd1);
            check("reset_rx_dst_rdy_n", 64'(fl.rx_dst_rdy_n), 64'(NIF'('1)));
            if (!rst) check("reset_tx_ifnum", 64'(fl.tx_ifnum), 64'd0);
            in_frame = 1'b0;
            last_eof = -1;
        end else if (!fl.tx_src_rdy_n) begin
            check("nongranted_rx_dst_rdy_n", 64'(fl.rx_dst_rdy_n | NIF'(1 << g)), 64'(NIF'('1)));
            check("granted_rx_dst_rdy_n", 64'(fl.rx_dst_rdy_n[g]), 64'(fl.tx_dst_rdy_n));
            if (!fl.tx_dst_rdy_n) begin
                if (in_frame) begin
                    check("no_interleave", 64'(g), 64'(cur_if));
                end else begin
                    if (order_q.size() > 0) check("grant_order", 64'(g), 64'(order_q.pop_front()));
                    if (check_gap && last_eof >= 0) check("bubble_cycles", 64'(cyc - last_eof), 64'd2);
                    if (lat_q.size() > 0) check("first_word_cycle", 64'(cyc), 64'(lat_q.pop_front()));
                end
                act = {fl.tx_data, fl.tx_rem, fl.tx_sof_n, fl.tx_sop_n, fl.tx_eop_n, fl.tx_eof_n};
                check("word_expected_on_input", 64'(exp_q[g].size() > 0), 64'd1);
                if (exp_q[g].size() > 0) check("tx_word", 64'(act), 64'(exp_q[g].pop_front()));
                in_frame = fl.tx_eof_n;
                cur_if   = g;
                if (!fl.tx_eof_n) last_eof = cyc;
            end
        end
        rst_prev = rst;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        int unsigned n;
        for (int i = 0; i < NIF; i++) begin
            cur_w[i]     = '1;
            cur_src_n[i] = 1'b1;
            xfer_cnt[i]  = 0;
        end

        do_reset(3);

        // Lone requester: 10/64/1-byte parts on input 2, first word one cycle after the request.
        check_lat = 1'b1;
        gen_frame(2, 10, 64, 1, 0);
        order_q.push_back(2);
        drain(200);
        check_lat = 1'b0;

        // All inputs continuously requesting: strict rotation with one bubble per frame.
        do_reset(2);
        check_gap = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int unsigned i = 0; i < NIF; i++) begin
                gen_frame(i, $urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(6, 1), 0);
                order_q.push_back(i);
            end
        drain(500);

        // Single-word frames everywhere: one transfer each, pointer wraps 3 -> 0.
        do_reset(2);
        for (int f = 0; f < 3; f++)
            for (int unsigned i = 0; i < NIF; i++) begin
                gen_single(i);
                order_q.push_back(i);
            end
        drain(200);
        check_gap = 1'b0;

        // Random TX backpressure with inputs 1 and 3 active.
        stall_pct = 50;
        for (int f = 0; f < 6; f++) begin
            gen_frame(1, $urandom_range(8, 1), $urandom_range(8, 1), $urandom_range(8, 1), 3);
            gen_frame(3, $urandom_range(8, 1), $urandom_range(8, 1), $urandom_range(8, 1), 3);
        end
        drain(2000);
        stall_pct = 0;

        // Reset in the middle of an input-1 frame while the pointer sits at 1.
        do_reset(2);
        gen_single(0);
        order_q.push_back(0);
        drain(100);
        gen_frame(1, 4, 4, 4, 0);
        xfer_cnt[1] = 0;
        n = 0;
        while (xfer_cnt[1] < 2 && n < 100) begin
            step();
            n++;
        end
        check("words_before_midframe_reset", 64'(xfer_cnt[1]), 64'd2);
        rst = 1'b1;
        flush_all();
        step();
        rst = 1'b0;
        gen_single(1);
        gen_single(0);
        order_q.push_back(0);
        order_q.push_back(1);
        drain(100);

        // Long random run: random inputs, sizes, source gaps and TX stalls.
        stall_pct = 30;
        for (int f = 0; f < 2000; f++)
            gen_frame($urandom_range(NIF - 1, 0), $urandom_range(6, 1), $urandom_range(6, 1),
                      $urandom_range(6, 1), 2);
        drain(70000);
        stall_pct = 0;

        for (int i = 0; i < NIF; i++) check("leftover_expected_words", 64'(exp_q[i].size()), 64'd0);
        check("leftover_order_entries", 64'(order_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
